pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer and run controller for the MIPS system. It replaces the gated system clock with a single free-running clock plus a one-cycle commit enable. It also adds run / single-step modes, edge-triggered PC load, exception capture (EPC plus cause) with halt and resume, and a retired-instruction counter. It sits between the control/ALU-status logic and IMEM/REG/DMEM; IMEM is addressed by PCS_pc, and REG/DMEM writes are qualified by PCS_commit.

## Interface
- PC_WIDTH, 8, width of PC, EPC and offsets
- RESET_PC, 0, PC value after reset
- CNT_WIDTH, 16, width of retired-instruction counter
- PCS_clk  in  1  system clock, all state on rising edge
- PCS_rst  in  1  reset, synchronous, active-high
- PCS_mode  in  1  0 = run continuously, 1 = single-step
- PCS_step  in  1  step request level (pre-synchronised); acts on rising edge
- PCS_load  in  1  PC load request level; acts on rising edge
- PCS_load_val  in  PC_WIDTH  value loaded into PC
- PCS_branch  in  1  branch instruction (control)
- PCS_zero  in  1  ALU zero flag
- PCS_branch_off  in  PC_WIDTH  sign-extended branch offset, truncated
- PCS_jump  in  1  jump instruction
- PCS_jump_off  in  PC_WIDTH  jump offset, truncated
- PCS_exc_en  in  1  instruction may raise an exception (control)
- PCS_exc_ovf, PCS_exc_addr, PCS_exc_div0  in  1 each  ALU exception flags
- PCS_resume  in  1  resume-from-halt request; acts on rising edge
- PCS_pc  out  PC_WIDTH  current PC (IMEM address)
- PCS_commit  out  1  combinational; current instruction retires this cycle
- PCS_epc  out  PC_WIDTH  PC of last faulting instruction
- PCS_cause  out  3  {div0, addr, ovf} of last exception
- PCS_halted  out  1  high in HALT state
- PCS_state  out  2  0 RUN, 1 WAIT, 2 HALT
- PCS_retired  out  CNT_WIDTH  count of committed instructions

## Operation
- Edge detect:
  - step_e, load_e and resume_e are rising edges of the respective inputs against a registered previous value.
  - Previous-value registers reset to 1, so an input held high through reset produces no edge.
- exc = PCS_exc_en & (ovf | addr | div0).
- advance = !rst & !load_e & ((state==RUN & mode==0) | (state==WAIT & step_e)).
- PCS_commit = advance & !exc.
- Next PC is computed modulo 2^PC_WIDTH:
  - if jump: pc + 1 + jump_off
  - else if branch & zero: pc + 1 + branch_off
  - else: pc + 1
- Jump has priority over branch.
- Per-cycle priority: rst > load_e > (HALT: resume_e) > advance.
  - rst: pc=RESET_PC, epc=0, cause=0, retired=0, state=RUN.
  - load_e (any state): pc=load_val; state=WAIT if mode else RUN. epc, cause and retired are kept.
  - commit: pc=next PC, retired+=1 (wraps at 2^CNT_WIDTH).
  - advance & exc: pc unchanged, epc=pc, cause={div0,addr,ovf}, state=HALT; retired unchanged.
  - HALT with resume_e: pc=epc+1 (faulting instruction skipped); state=WAIT if mode else RUN. Cause stays sticky until the next exception or reset.
  - HALT otherwise: everything holds; step and mode are ignored.
- Mode transitions:
  - RUN with mode=1: next state WAIT, no advance in that cycle.
  - WAIT with mode=0: next state RUN; a coincident step_e still advances one instruction.

## Timing
- Reset values: PCS_pc=RESET_PC, PCS_epc=0, PCS_cause=0, PCS_halted=0, PCS_state=0, PCS_retired=0, PCS_commit=0.
- PCS_commit is combinational in the cycle the instruction executes; the PC update is visible on the next edge (zero-latency enable, one-cycle PC update).
- In run mode: one instruction per cycle.
- In step mode: exactly one instruction per step rising edge; holding step high gives one advance only.
- Exception: PCS_halted rises on the edge after the faulting cycle; PCS_commit is 0 in the faulting cycle, so no REG/DMEM write occurs.
- load_e coincident with exc: load wins, no EPC capture.
- resume_e coincident with load_e: load wins.
- rst mid-operation (any state) returns to reset values on the next edge; edges on inputs during rst are discarded.

## Test plan
- Reset, mode=0, no branch/jump, 5 cycles -> PCS_pc 0,1,2,3,4,5; PCS_retired=5; PCS_commit=1 every cycle.
- pc=3, branch=1, zero=1, branch_off=0xFE -> next pc=2. Same with jump=1, jump_off=4 -> next pc=8 (jump priority). pc=0xFF, no branch/jump -> next pc=0.
- pc=6, exc_en=1, ovf=1 -> commit=0 that cycle; next edge: state=HALT, epc=6, cause=3'b001, pc stays 6. Then resume pulse -> pc=7, state=RUN.
- mode=1 -> state WAIT, pc static. Step held high 10 cycles -> exactly one advance. Two separate step pulses -> pc +2, retired +2.
- load_val=0x40, load pulse while in HALT -> pc=0x40, state=RUN, epc/cause unchanged. Load held high -> single load; load coincident with exc -> no HALT.
- rst asserted mid-HALT with step/resume high -> all outputs at reset values; releasing rst with inputs still high produces no edges.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer and run controller. A free-running clock plus a
// one-cycle commit enable replaces the old gated clock. Provides run and
// single-step modes, edge-triggered PC load, exception capture (EPC + cause)
// with halt/resume, and a retired-instruction counter.
module pc_sequencer #(
    parameter int                  PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 16
) (
    input  logic                 PCS_clk,
    input  logic                 PCS_rst,
    input  logic                 PCS_mode,
    input  logic                 PCS_step,
    input  logic                 PCS_load,
    input  logic [PC_WIDTH-1:0]  PCS_load_val,
    input  logic                 PCS_branch,
    input  logic                 PCS_zero,
    input  logic [PC_WIDTH-1:0]  PCS_branch_off,
    input  logic                 PCS_jump,
    input  logic [PC_WIDTH-1:0]  PCS_jump_off,
    input  logic                 PCS_exc_en,
    input  logic                 PCS_exc_ovf,
    input  logic                 PCS_exc_addr,
    input  logic                 PCS_exc_div0,
    input  logic                 PCS_resume,
    output logic [PC_WIDTH-1:0]  PCS_pc,
    output logic                 PCS_commit,
    output logic [PC_WIDTH-1:0]  PCS_epc,
    output logic [2:0]           PCS_cause,
    output logic                 PCS_halted,
    output logic [1:0]           PCS_state,
    output logic [CNT_WIDTH-1:0] PCS_retired
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Request edge detection: bit 0 = step, bit 1 = load, bit 2 = resume
    logic [2:0] w_req_level;
    logic [2:0] r_req_prev;
    logic [2:0] w_req_rise;
    logic       w_step_e;
    logic       w_load_e;
    logic       w_resume_e;

    // FSM
    state_t r_state;
    state_t w_state_next;
    state_t w_resume_state;

    // Datapath registers
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  r_epc;
    logic [2:0]           r_cause;
    logic [CNT_WIDTH-1:0] r_retired;

    // Control / datapath wires
    logic                w_exc;
    logic                w_advance;
    logic                w_commit;
    logic                w_halted;
    logic [PC_WIDTH-1:0] w_pc_seq;
    logic [PC_WIDTH-1:0] w_pc_target;

    assign w_req_level = {PCS_resume, PCS_load, PCS_step};

    // Previous-level registers preset to 1 so a level held through reset
    // never looks like a fresh rising edge once reset releases.
    always_ff @(posedge PCS_clk) begin
        if (PCS_rst) begin
            r_req_prev <= 3'b111;
        end else begin
            r_req_prev <= w_req_level;
        end
    end

    assign w_req_rise = w_req_level & ~r_req_prev;
    assign w_step_e   = w_req_rise[0];
    assign w_load_e   = w_req_rise[1];
    assign w_resume_e = w_req_rise[2];

    // Exception only counts when the current instruction is allowed to raise one
    assign w_exc = PCS_exc_en & (PCS_exc_ovf | PCS_exc_addr | PCS_exc_div0);

    // An instruction executes this cycle when running freely or when a step
    // edge arrives in WAIT; reset and a PC load both pre-empt it.
    assign w_advance = ~PCS_rst & ~w_load_e &
                       (((r_state == ST_RUN) & ~PCS_mode) |
                        ((r_state == ST_WAIT) & w_step_e));

    // Sequential next PC; jump takes priority over a taken branch.
    // All arithmetic wraps naturally at PC_WIDTH bits.
    assign w_pc_seq = r_pc + PC_ONE;
    always_comb begin
        w_pc_target = w_pc_seq;
        if (PCS_jump) begin
            w_pc_target = w_pc_seq + PCS_jump_off;
        end else if (PCS_branch & PCS_zero) begin
            w_pc_target = w_pc_seq + PCS_branch_off;
        end
    end

    // FSM state register
    always_ff @(posedge PCS_clk) begin
        if (PCS_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Where the sequencer lands after a load or resume: follows the mode input
    assign w_resume_state = PCS_mode ? ST_WAIT : ST_RUN;

    // FSM next-state logic; priority is load edge, then HALT handling, then
    // exception capture, otherwise track the mode input.
    always_comb begin
        w_state_next = r_state;
        if (PCS_rst) begin
            w_state_next = ST_RUN;
        end else if (w_load_e) begin
            w_state_next = w_resume_state;
        end else begin
            case (r_state)
                ST_HALT: begin
                    if (w_resume_e) begin
                        w_state_next = w_resume_state;
                    end
                end
                ST_RUN, ST_WAIT: begin
                    if (w_advance & w_exc) begin
                        w_state_next = ST_HALT;
                    end else begin
                        w_state_next = w_resume_state;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    // FSM outputs: commit is the zero-latency write enable for REG/DMEM
    always_comb begin
        w_commit = w_advance & ~w_exc;
        w_halted = (r_state == ST_HALT);
    end

    // PC, EPC and cause update with the same priority as the FSM
    always_ff @(posedge PCS_clk) begin
        if (PCS_rst) begin
            r_pc    <= RESET_PC;
            r_epc   <= '0;
            r_cause <= 3'b000;
        end else if (w_load_e) begin
            r_pc <= PCS_load_val;
        end else if (r_state == ST_HALT) begin
            // Resume skips the faulting instruction
            if (w_resume_e) begin
                r_pc <= r_epc + PC_ONE;
            end
        end else if (w_advance & w_exc) begin
            // PC holds on the faulting instruction; cause stays sticky afterwards
            r_epc   <= r_pc;
            r_cause <= {PCS_exc_div0, PCS_exc_addr, PCS_exc_ovf};
        end else if (w_commit) begin
            r_pc <= w_pc_target;
        end
    end

    // Retired-instruction counter, wraps at 2^CNT_WIDTH
    always_ff @(posedge PCS_clk) begin
        if (PCS_rst) begin
            r_retired <= '0;
        end else if (w_commit) begin
            r_retired <= r_retired + CNT_ONE;
        end
    end

    assign PCS_pc      = r_pc;
    assign PCS_commit  = w_commit;
    assign PCS_epc     = r_epc;
    assign PCS_cause   = r_cause;
    assign PCS_halted  = w_halted;
    assign PCS_state   = r_state;
    assign PCS_retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// stimulus, checked through a scoreboard queue against a behavioural model.
module tb_pc_sequencer;

    localparam int PCW = 8;
    localparam int CW  = 16;

    logic           clk;
    logic           rst;
    logic           mode, step, load, branch, zero, jump;
    logic [PCW-1:0] load_val, branch_off, jump_off;
    logic           exc_en, exc_ovf, exc_addr, exc_div0, resume;
    logic [PCW-1:0] pc, epc;
    logic           commit, halted;
    logic [2:0]     cause;
    logic [1:0]     state;
    logic [CW-1:0]  retired;

    pc_sequencer #(.PC_WIDTH(PCW), .RESET_PC(8'h00), .CNT_WIDTH(CW)) dut (
        .PCS_clk(clk), .PCS_rst(rst), .PCS_mode(mode), .PCS_step(step),
        .PCS_load(load), .PCS_load_val(load_val), .PCS_branch(branch),
        .PCS_zero(zero), .PCS_branch_off(branch_off), .PCS_jump(jump),
        .PCS_jump_off(jump_off), .PCS_exc_en(exc_en), .PCS_exc_ovf(exc_ovf),
        .PCS_exc_addr(exc_addr), .PCS_exc_div0(exc_div0), .PCS_resume(resume),
        .PCS_pc(pc), .PCS_commit(commit), .PCS_epc(epc), .PCS_cause(cause),
        .PCS_halted(halted), .PCS_state(state), .PCS_retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus shadow inputs, copied onto the DUT pins at each falling edge
    logic           s_rst, s_mode, s_step, s_load, s_branch, s_zero, s_jump;
    logic [PCW-1:0] s_load_val, s_branch_off, s_jump_off;
    logic           s_exc_en, s_ovf, s_addr, s_div0, s_resume;

    typedef struct {
        int pc; int commit; int epc; int cause; int halted; int state; int retired;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_cycles = 0;

    // Behavioural model state (mode names as integers: 0 run, 1 wait, 2 halt)
    int  m_pc = 0, m_epc = 0, m_cause = 0, m_ret = 0, m_state = 0;
    bit  m_pstep = 1, m_pload = 1, m_presume = 1;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic clr();
        s_step = 0; s_load = 0; s_branch = 0; s_zero = 0; s_jump = 0;
        s_load_val = 0; s_branch_off = 0; s_jump_off = 0;
        s_exc_en = 0; s_ovf = 0; s_addr = 0; s_div0 = 0; s_resume = 0;
    endtask

    // Compute what the DUT must show during this cycle, queue it, then move
    // the model on to the state after the coming rising edge.
    task automatic model_cycle();
        exp_t e;
        bit   se, le, re, exc, runs, adv, com;
        int   tgt;
        int   after_mode;
        se  = s_step & ~m_pstep;
        le  = s_load & ~m_pload;
        re  = s_resume & ~m_presume;
        exc = s_exc_en && (s_ovf || s_addr || s_div0);
        runs = (m_state == 0 && !s_mode) || (m_state == 1 && se);
        adv  = !s_rst && !le && runs;
        com  = adv && !exc;
        e.pc = m_pc; e.epc = m_epc; e.cause = m_cause; e.retired = m_ret;
        e.state = m_state; e.halted = (m_state == 2) ? 1 : 0; e.commit = com ? 1 : 0;
        sb_q.push_back(e);
        after_mode = s_mode ? 1 : 0;
        if (s_rst) begin
            m_pc = 0; m_epc = 0; m_cause = 0; m_ret = 0; m_state = 0;
            m_pstep = 1; m_pload = 1; m_presume = 1;
        end else begin
            if (le) begin
                m_pc = int'(s_load_val); m_state = after_mode;
            end else if (m_state == 2) begin
                if (re) begin
                    m_pc = (m_epc + 1) % 256; m_state = after_mode;
                end
            end else if (adv && exc) begin
                m_epc = m_pc; m_state = 2;
                m_cause = 4 * int'(s_div0) + 2 * int'(s_addr) + int'(s_ovf);
            end else begin
                if (com) begin
                    if (s_jump) tgt = m_pc + 1 + int'(s_jump_off);
                    else if (s_branch && s_zero) tgt = m_pc + 1 + int'(s_branch_off);
                    else tgt = m_pc + 1;
                    m_pc  = tgt % 256;
                    m_ret = (m_ret + 1) % 65536;
                end
                m_state = after_mode;
            end
            m_pstep = s_step; m_pload = s_load; m_presume = s_resume;
        end
    endtask

    // One stimulus cycle: apply shadows at the falling edge and queue expectations
    task automatic cyc();
        @(negedge clk);
        rst = s_rst; mode = s_mode; step = s_step; load = s_load; load_val = s_load_val;
        branch = s_branch; zero = s_zero; branch_off = s_branch_off; jump = s_jump;
        jump_off = s_jump_off; exc_en = s_exc_en; exc_ovf = s_ovf; exc_addr = s_addr;
        exc_div0 = s_div0; resume = s_resume;
        model_cycle();
        n_cycles++;
    endtask

    // Wait for the rising edge that applies the last queued cycle
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the queue head
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc", int'(pc), e.pc);
            chk("commit", int'(commit), e.commit);
            chk("epc", int'(epc), e.epc);
            chk("cause", int'(cause), e.cause);
            chk("halted", int'(halted), e.halted);
            chk("state", int'(state), e.state);
            chk("retired", int'(retired), e.retired);
            $display("cyc pc=%02h commit=%0d state=%0d epc=%02h cause=%0d retired=%0d",
                     pc, commit, state, epc, cause, retired);
        end
    end

    initial begin
        rst = 1; mode = 0; step = 0; load = 0; load_val = 0; branch = 0; zero = 0;
        branch_off = 0; jump = 0; jump_off = 0; exc_en = 0; exc_ovf = 0;
        exc_addr = 0; exc_div0 = 0; resume = 0;
        clr(); s_rst = 1; s_mode = 0;

        // Reset then five free-running cycles
        cyc(); cyc();
        s_rst = 0;
        repeat (5) cyc();
        after_edge();
        chk("run5_pc", int'(pc), 5);
        chk("run5_retired", int'(retired), 5);

        // Taken branch with negative offset from pc=3
        s_load = 1; s_load_val = 8'h03; cyc();
        s_load = 0; s_branch = 1; s_zero = 1; s_branch_off = 8'hFE; cyc();
        after_edge();
        chk("branch_pc", int'(pc), 2);

        // Jump beats a taken branch
        s_load = 1; s_load_val = 8'h03; cyc();
        s_load = 0; s_jump = 1; s_jump_off = 8'h04; cyc();
        after_edge();
        chk("jump_pc", int'(pc), 8);

        // Wrap at the top of the address space
        clr(); s_load = 1; s_load_val = 8'hFF; cyc();
        s_load = 0; cyc();
        after_edge();
        chk("wrap_pc", int'(pc), 0);

        // Overflow exception at pc=6, then resume
        s_load = 1; s_load_val = 8'h06; cyc();
        s_load = 0; s_exc_en = 1; s_ovf = 1; cyc();
        after_edge();
        chk("exc_state", int'(state), 2);
        chk("exc_epc", int'(epc), 6);
        chk("exc_cause", int'(cause), 1);
        chk("exc_pc", int'(pc), 6);
        chk("exc_halted", int'(halted), 1);
        clr(); cyc(); cyc();
        s_resume = 1; cyc();
        after_edge();
        chk("resume_pc", int'(pc), 7);
        chk("resume_state", int'(state), 0);
        s_resume = 0;

        // Single-step mode: held step gives one advance, two pulses give two
        s_mode = 1; cyc();
        after_edge();
        chk("wait_state", int'(state), 1);
        chk("wait_pc", int'(pc), 7);
        s_step = 1; repeat (10) cyc();
        after_edge();
        chk("step_held_pc", int'(pc), 8);
        s_step = 0; cyc(); s_step = 1; cyc(); s_step = 0; cyc();
        s_step = 1; cyc(); s_step = 0; cyc();
        after_edge();
        chk("step_pulses_pc", int'(pc), 10);

        // Address exception, then load while halted
        s_mode = 0; cyc();
        s_exc_en = 1; s_addr = 1; cyc();
        clr(); cyc();
        s_load = 1; s_load_val = 8'h40; cyc();
        after_edge();
        chk("halt_load_pc", int'(pc), 8'h40);
        chk("halt_load_state", int'(state), 0);
        chk("halt_load_epc", int'(epc), 10);
        chk("halt_load_cause", int'(cause), 2);
        repeat (3) cyc();
        s_load = 0; cyc();
        s_load = 1; s_exc_en = 1; s_div0 = 1; cyc();
        after_edge();
        chk("load_vs_exc_pc", int'(pc), 8'h40);
        chk("load_vs_exc_halted", int'(halted), 0);
        clr();

        // Reset in HALT with step/resume high; release with them still high
        s_exc_en = 1; s_ovf = 1; cyc();
        clr(); s_step = 1; s_resume = 1; s_rst = 1; s_mode = 1; cyc(); cyc();
        after_edge();
        chk("rst_pc", int'(pc), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_cause", int'(cause), 0);
        chk("rst_retired", int'(retired), 0);
        s_rst = 0; repeat (3) cyc();
        after_edge();
        chk("post_rst_pc", int'(pc), 0);
        chk("post_rst_state", int'(state), 1);
        clr(); s_mode = 0;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            s_rst        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) s_mode = ~s_mode;
            s_step       = ($urandom_range(0, 2) == 0);
            s_load       = ($urandom_range(0, 11) == 0);
            s_load_val   = 8'($urandom);
            s_branch     = $urandom_range(0, 1) == 1;
            s_zero       = $urandom_range(0, 1) == 1;
            s_branch_off = 8'($urandom);
            s_jump       = ($urandom_range(0, 3) == 0);
            s_jump_off   = 8'($urandom);
            s_exc_en     = ($urandom_range(0, 7) == 0);
            s_ovf        = $urandom_range(0, 1) == 1;
            s_addr       = $urandom_range(0, 1) == 1;
            s_div0       = $urandom_range(0, 1) == 1;
            s_resume     = ($urandom_range(0, 3) == 0);
            cyc();
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
